// File: rtl/vproc_pkg.sv
// Shared vector-processor types: the per-slot record kept by the hazard tracker.
// The mask width of hazard_slot_t follows VREG_CNT_DEF; trackers are built with that register count.
package vproc_pkg;

    localparam int unsigned VREG_CNT_DEF = 32;
    localparam int unsigned SLOT_CNT_DEF = 8;
    localparam int unsigned REL_CNT_DEF  = 4;

    typedef struct packed {
        logic                    valid;
        logic [VREG_CNT_DEF-1:0] rd_mask;
        logic [VREG_CNT_DEF-1:0] wr_mask;
    } hazard_slot_t;

endpackage

// File: rtl/vproc_hazard_slot_alloc.sv
// First-free slot finder: lowest index whose valid bit is clear.
module vproc_hazard_slot_alloc #(
    parameter int unsigned SLOT_CNT = 8,
    parameter int unsigned ID_W     = $clog2(SLOT_CNT)
) (
    input  logic [SLOT_CNT-1:0] valid_i,
    output logic                free_o,
    output logic [ID_W-1:0]     idx_o
);

    // Scan from the top so the lowest free index is the last one written.
    always_comb begin
        free_o = 1'b0;
        idx_o  = '0;
        for (int i = SLOT_CNT - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_o = 1'b1;
                idx_o  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/vproc_hazard_tracker.sv
// In-flight vector instruction scoreboard: gates issue on RAW/WAR/WAW and full,
// releases read hazards and retires slots from several execution-unit ports.
module vproc_hazard_tracker
    import vproc_pkg::*;
#(
    parameter  int unsigned VREG_CNT = VREG_CNT_DEF,
    parameter  int unsigned SLOT_CNT = SLOT_CNT_DEF,
    parameter  int unsigned REL_CNT  = REL_CNT_DEF,
    localparam int unsigned ID_W     = $clog2(SLOT_CNT)
) (
    input  logic                    clk_i,
    input  logic                    async_rst_ni,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [VREG_CNT-1:0]     issue_rd_hazards_i,
    input  logic [VREG_CNT-1:0]     issue_wr_hazards_i,
    output logic [ID_W-1:0]         issue_id_o,
    input  logic [REL_CNT-1:0]      rdrel_valid_i,
    input  logic [REL_CNT*ID_W-1:0] rdrel_id_i,
    input  logic [REL_CNT-1:0]      retire_valid_i,
    input  logic [REL_CNT*ID_W-1:0] retire_id_i,
    output logic [VREG_CNT-1:0]     pend_rd_o,
    output logic [VREG_CNT-1:0]     pend_wr_o,
    output logic [ID_W:0]           occupancy_o,
    output logic                    idle_o,
    output logic                    err_o
);

    hazard_slot_t        slot_q [SLOT_CNT];
    hazard_slot_t        slot_d [SLOT_CNT];
    logic                err_q, err_d;
    logic [SLOT_CNT-1:0] valid_vec;
    logic                alloc_free;
    logic [ID_W-1:0]     alloc_idx;
    logic                stall_raw, stall_waw, stall_war;
    logic                handshake;
    logic [ID_W-1:0]     sel_id;

    always_comb begin
        valid_vec   = '0;
        pend_rd_o   = '0;
        pend_wr_o   = '0;
        occupancy_o = '0;
        for (int s = 0; s < SLOT_CNT; s++) begin
            valid_vec[s] = slot_q[s].valid;
            if (slot_q[s].valid) begin
                pend_rd_o   = pend_rd_o | slot_q[s].rd_mask;
                pend_wr_o   = pend_wr_o | slot_q[s].wr_mask;
                occupancy_o = occupancy_o + 1'b1;
            end
        end
    end

    assign idle_o = ~|valid_vec;
    assign err_o  = err_q;

    vproc_hazard_slot_alloc #(
        .SLOT_CNT (SLOT_CNT),
        .ID_W     (ID_W)
    ) u_alloc (
        .valid_i (valid_vec),
        .free_o  (alloc_free),
        .idx_o   (alloc_idx)
    );

    // Conflicts are judged against registered state only; a release in this cycle does not unblock it.
    assign stall_raw     = |(issue_rd_hazards_i & pend_wr_o);
    assign stall_waw     = |(issue_wr_hazards_i & pend_wr_o);
    assign stall_war     = |(issue_wr_hazards_i & pend_rd_o);
    assign issue_ready_o = alloc_free & ~stall_raw & ~stall_waw & ~stall_war;
    assign issue_id_o    = alloc_idx;
    assign handshake     = issue_valid_i & issue_ready_o;

    always_comb begin
        err_d  = err_q;
        sel_id = '0;
        for (int s = 0; s < SLOT_CNT; s++) begin
            slot_d[s] = slot_q[s];
        end
        for (int p = 0; p < REL_CNT; p++) begin
            if (rdrel_valid_i[p]) begin
                sel_id = rdrel_id_i[p*ID_W +: ID_W];
                if (slot_q[sel_id].valid) begin
                    slot_d[sel_id].rd_mask = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        for (int p = 0; p < REL_CNT; p++) begin
            if (retire_valid_i[p]) begin
                sel_id = retire_id_i[p*ID_W +: ID_W];
                if (slot_q[sel_id].valid) begin
                    slot_d[sel_id] = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        // The allocated slot is invalid in slot_q, so no release above can have touched it.
        if (handshake) begin
            slot_d[alloc_idx].valid   = 1'b1;
            slot_d[alloc_idx].rd_mask = issue_rd_hazards_i;
            slot_d[alloc_idx].wr_mask = issue_wr_hazards_i;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int s = 0; s < SLOT_CNT; s++) begin
                slot_q[s] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int s = 0; s < SLOT_CNT; s++) begin
                slot_q[s] <= slot_d[s];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_vproc_hazard_tracker.sv
// Directed bench for vproc_hazard_tracker: issued ids go through an expected-id queue
// checked by a monitor on each handshake; status outputs are checked against hand values.
module tb_vproc_hazard_tracker;

    localparam int VREG = 32;
    localparam int SLOTS = 8;
    localparam int REL = 4;
    localparam int IDW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [VREG-1:0]  issue_rd = '0;
    logic [VREG-1:0]  issue_wr = '0;
    logic [IDW-1:0]   issue_id;
    logic [REL-1:0]   rdrel_valid = '0;
    logic [REL*IDW-1:0] rdrel_id = '0;
    logic [REL-1:0]   retire_valid = '0;
    logic [REL*IDW-1:0] retire_id = '0;
    logic [VREG-1:0]  pend_rd, pend_wr;
    logic [IDW:0]     occupancy;
    logic             idle, err;

    int vectors = 0;
    int miscompares = 0;
    logic [IDW-1:0] exp_q[$];

    vproc_hazard_tracker dut (
        .clk_i              (clk),
        .async_rst_ni       (rst_n),
        .issue_valid_i      (issue_valid),
        .issue_ready_o      (issue_ready),
        .issue_rd_hazards_i (issue_rd),
        .issue_wr_hazards_i (issue_wr),
        .issue_id_o         (issue_id),
        .rdrel_valid_i      (rdrel_valid),
        .rdrel_id_i         (rdrel_id),
        .retire_valid_i     (retire_valid),
        .retire_id_i        (retire_id),
        .pend_rd_o          (pend_rd),
        .pend_wr_o          (pend_wr),
        .occupancy_o        (occupancy),
        .idle_o             (idle),
        .err_o              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got id %0d expected no handshake at %0t", issue_id, $time);
            end else begin
                check("issue_id", 32'(issue_id), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [VREG-1:0] rd, input logic [VREG-1:0] wr, input int exp_id);
        bit ok = 0;
        exp_q.push_back(IDW'(exp_id));
        issue_valid = 1'b1;
        issue_rd = rd;
        issue_wr = wr;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (issue_ready) begin
                ok = 1;
                break;
            end
        end
        tick();
        issue_valid = 1'b0;
        if (!ok) begin
            void'(exp_q.pop_back());
            check("issue_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic set_retire(input int p, input int id);
        retire_valid[p] = 1'b1;
        retire_id[p*IDW +: IDW] = IDW'(id);
    endtask

    task automatic set_rdrel(input int p, input int id);
        rdrel_valid[p] = 1'b1;
        rdrel_id[p*IDW +: IDW] = IDW'(id);
    endtask

    task automatic clear_rel();
        rdrel_valid = '0;
        retire_valid = '0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_ready", 32'(issue_ready), 32'd1);
        check("rst_id", 32'(issue_id), 32'd0);
        check("rst_pend_rd", pend_rd, 32'h0);
        check("rst_pend_wr", pend_wr, 32'h0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;

        // First issue lands in slot 0
        do_issue(32'h6, 32'h1, 0);
        check("t1_pend_rd", pend_rd, 32'h6);
        check("t1_pend_wr", pend_wr, 32'h1);
        check("t1_occ", 32'(occupancy), 32'd1);
        check("t1_idle", 32'(idle), 32'd0);

        // WAR: write v2 while slot 0 still reads it
        issue_valid = 1'b1; issue_rd = '0; issue_wr = 32'h4;
        @(negedge clk);
        check("war_stall", 32'(issue_ready), 32'd0);
        tick();
        set_rdrel(1, 0);
        @(negedge clk);
        check("war_no_bypass", 32'(issue_ready), 32'd0);
        tick();
        clear_rel();
        check("war_pend_rd_cleared", pend_rd, 32'h0);
        check("war_pend_wr_held", pend_wr, 32'h1);
        do_issue(32'h0, 32'h4, 1);
        check("war_pend_wr_after", pend_wr, 32'h5);
        check("war_occ", 32'(occupancy), 32'd2);

        // RAW: read v0 while slot 0 writes it; retire frees slot 0
        issue_valid = 1'b1; issue_rd = 32'h1; issue_wr = '0;
        @(negedge clk);
        check("raw_stall", 32'(issue_ready), 32'd0);
        tick();
        set_retire(3, 0);
        @(negedge clk);
        check("raw_no_bypass", 32'(issue_ready), 32'd0);
        tick();
        clear_rel();
        do_issue(32'h1, 32'h0, 0);
        check("raw_pend_rd", pend_rd, 32'h1);
        check("raw_pend_wr", pend_wr, 32'h4);

        // Drain both slots in one cycle
        set_retire(0, 0);
        set_retire(1, 1);
        tick();
        clear_rel();
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_idle", 32'(idle), 32'd1);

        // Fill all eight slots with disjoint masks
        for (int i = 0; i < SLOTS; i++) begin
            do_issue(VREG'(1) << (16 + i), VREG'(1) << (8 + i), i);
        end
        check("full_occ", 32'(occupancy), 32'd8);
        issue_valid = 1'b1; issue_rd = '0; issue_wr = 32'h4000_0000;
        @(negedge clk);
        check("full_stall", 32'(issue_ready), 32'd0);
        check("full_id", 32'(issue_id), 32'd0);
        tick();
        set_retire(2, 3);
        @(negedge clk);
        check("full_retire_same_cycle", 32'(issue_ready), 32'd0);
        tick();
        clear_rel();
        do_issue(32'h0, 32'h4000_0000, 3);
        check("refill_occ", 32'(occupancy), 32'd8);

        // Two retires on different ports while an issue waits
        issue_valid = 1'b1; issue_rd = '0; issue_wr = 32'h8000_0000;
        set_retire(0, 1);
        set_retire(2, 5);
        @(negedge clk);
        check("dual_occ_before", 32'(occupancy), 32'd8);
        tick();
        clear_rel();
        check("dual_occ_after", 32'(occupancy), 32'd6);
        do_issue(32'h0, 32'h8000_0000, 1);
        check("dual_occ_issue", 32'(occupancy), 32'd7);

        // Legal retire of slot 6, then a retire to the now-free slot raises err
        set_retire(1, 6);
        tick();
        clear_rel();
        check("err_clean", 32'(err), 32'd0);
        set_retire(1, 6);
        tick();
        clear_rel();
        check("err_set", 32'(err), 32'd1);
        check("err_pend_wr", pend_wr, 32'hC000_9500);
        check("err_pend_rd", pend_rd, 32'h0095_0000);
        check("err_occ", 32'(occupancy), 32'd6);
        tick();
        check("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-stream
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_pend_rd", pend_rd, 32'h0);
        check("arst_pend_wr", pend_wr, 32'h0);
        check("arst_idle", 32'(idle), 32'd1);
        check("arst_err", 32'(err), 32'd0);
        check("arst_ready", 32'(issue_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        do_issue(32'h6, 32'h1, 0);
        check("post_rst_occ", 32'(occupancy), 32'd1);

        // Read release and retire of the same slot in one cycle
        set_retire(0, 0);
        set_rdrel(3, 0);
        tick();
        clear_rel();
        check("combo_occ", 32'(occupancy), 32'd0);
        check("combo_err", 32'(err), 32'd0);

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
